// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with valid/ready handshakes.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hs, hc, s_bit, c_next;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    hs     = a_q[0] ^ b_q[0];
    hc     = a_q[0] & b_q[0];
    s_bit  = hs ^ c_q;
    c_next = hc | (c_q & hs);

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d = {s_bit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_next;
        cnt_d = cnt_q + CNT_W'(1);
        // Outputs are only published on the final shift, so they hold the previous result meanwhile.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = res_d;
          cout_d  = c_next;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = c_q ^ c_next;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized and directed checks of serial_adder against a transaction-level model.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Transaction model: 0 = waiting for operands, 1 = computing, 2 = holding result.
  int           m_phase = 0;
  int           m_edges = 0;
  logic [W:0]   m_pend = '0;
  logic         m_pend_ovf = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;

  always @(posedge clk) begin
    int sa;
    cyc++;
    if (!rst_n) begin
      m_phase = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
          sa = int'($signed(a)) + int'($signed(b)) + int'(cin);
          m_pend_ovf = (sa > (2 ** (W - 1)) - 1) || (sa < -(2 ** (W - 1)));
          m_phase = 1;
          m_edges = 0;
        end
        1: begin
          m_edges++;
          if (m_edges == W) begin
            m_phase = 2;
            m_sum = m_pend[W-1:0];
            m_cout = m_pend[W];
            m_ovf = m_pend_ovf;
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
    #1;
    chk("in_ready", in_ready, m_phase == 0);
    chk("busy", busy, m_phase != 0);
    chk("out_valid", out_valid, m_phase == 2);
    chk("sum", sum, m_sum);
    chk("cout", cout, m_cout);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", ovf, m_ovf);
`endif
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic [W-1:0] esum, input logic ecout, input logic eovf);
    int guard = 0;
    int edges = 0;
    @(negedge clk);
    while (!in_ready && guard < 40) begin @(negedge clk); guard++; end
    chk("op_ready_timeout", guard < 40, 1);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #2;
    in_valid = 1'b0;
    a = ~ta; b = ~tb_; cin = ~tc;
    while (!out_valid && edges < 40) begin @(posedge clk); #2; edges++; end
    chk("op_latency", edges, W);
    chk("op_sum", sum, esum);
    chk("op_cout", cout, ecout);
`ifdef SERIAL_ADDER_OVF_EN
    chk("op_ovf", ovf, eovf);
`else
    if (eovf === 1'bx) chk("op_ovf_arg", 0, 1);
`endif
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("release_idle", in_ready, 1);
    chk("release_valid", out_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int guard;
    #2;
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("rst_ready", in_ready, 1);

    run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
    release_result();
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    release_result();
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Backpressure: result must hold while new operands are offered.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'h12 + 8'(i); b = 8'h34; cin = 1'b1; out_ready = 1'b0;
      @(posedge clk); #2;
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", sum, 8'hFF);
      chk("bp_cout", cout, 1);
      chk("bp_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result();

    // Reset during the shift phase.
    run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
    release_result();
    @(negedge clk);
    a = 8'h77; b = 8'h11; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_noresult", out_valid, 0);

    // Back-to-back random operations.
    in_valid = 1'b1;
    out_ready = 1'b1;
    prev = -1;
    for (int n = 0; n < 40; n++) begin
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 30) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        @(negedge clk);
        guard++;
      end
      chk("b2b_timeout", guard < 30, 1);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (prev >= 0) chk("b2b_spacing", cyc - prev, W + 2);
      prev = cyc;
      @(posedge clk); #2;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (W + 4) @(posedge clk);
    #3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands a, b and cin are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: the registered result.
REQ-012 The block SHALL have port cout, output, 1 bit: the registered carry-out.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in SHIFT and DONE it SHALL be 0.
REQ-016 On a rising edge with in_valid and in_ready both high, the block SHALL:
- latch a and b into shift registers;
- load the carry flop with cin;
- clear the bit counter;
- enter SHIFT.
REQ-017 Each SHIFT cycle SHALL process operand bit 0 (LSB first) as a full adder built from two half-adder cells plus an OR:
- s = a0^b0^c;
- c' = (a0&b0) | (c&(a0^b0)).
REQ-018 Each SHIFT cycle SHALL then shift s into the result register MSB, shift both operand registers right by one, and increment the counter.
REQ-019 The counter SHALL be ceil(log2(WIDTH+1)) bits wide.
REQ-020 After exactly WIDTH SHIFT cycles the FSM SHALL enter DONE.
REQ-021 On entering DONE, sum SHALL equal (a+b+cin) mod 2^WIDTH and cout SHALL equal bit WIDTH of that sum.
REQ-022 out_valid SHALL rise on the WIDTH-th rising edge after the accepting edge.
REQ-023 In DONE, out_valid SHALL be 1, and sum and cout SHALL stay stable until a rising edge with out_ready high.
REQ-024 On that out_ready edge the FSM SHALL return to IDLE.
REQ-025 out_valid SHALL be 0 in IDLE and SHIFT.
REQ-026 in_valid SHALL be ignored outside IDLE, and a/b/cin changes during SHIFT SHALL not affect the result.
REQ-027 sum and cout SHALL retain the last result through IDLE and SHIFT; the result register SHALL update only while shifting.
REQ-028 Maximum throughput SHALL be one operation per WIDTH+2 cycles.

Reset
REQ-029 While rst_n is low, regardless of clk, the block SHALL:
- force state to IDLE;
- force sum, cout, out_valid, busy, the counter, the carry flop and the operand registers to 0.
REQ-030 An assertion of rst_n mid-operation SHALL abort the operation with no result produced.
REQ-031 in_ready SHALL be 1 from the first cycle after rst_n deasserts.

Configuration
REQ-032 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add output port ovf (1 bit): signed overflow, equal to (carry into the MSB) XOR cout.
REQ-033 ovf SHALL be registered, valid whenever out_valid is high, and reset to 0.
REQ-034 Without SERIAL_ADDER_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-035 The bench SHALL cover a basic add:
- stimulus: a=0x5A, b=0x33, cin=0, accepted;
- response: out_valid at the 8th edge after accept, sum=0x8D, cout=0, ovf=1.
REQ-036 The bench SHALL cover carry wrap:
- stimulus: a=0xFF, b=0x01, cin=0;
- response: sum=0x00, cout=1, ovf=0.
REQ-037 The bench SHALL cover carry-in:
- stimulus: a=0xFF, b=0xFF, cin=1;
- response: sum=0xFF, cout=1, ovf=0.
REQ-038 The bench SHALL cover backpressure:
- stimulus: out_ready held 0 for 5 cycles in DONE while in_valid=1 with new operands;
- response: out_valid=1, sum/cout unchanged, in_ready=0, no new accept.
- follow-on: out_ready=1 gives IDLE on the next edge.
REQ-039 The bench SHALL cover reset mid-operation:
- stimulus: rst_n pulsed low after 4 SHIFT cycles;
- response: sum=0, cout=0, out_valid=0, busy=0 immediately; in_ready=1 after release.
REQ-040 The bench SHALL cover back-to-back operation:
- stimulus: in_valid and out_ready held 1 with random operands;
- response: accepts spaced exactly 10 cycles apart, every result matching the reference sum.
